// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, imem req/ack fetch, one-entry skid and IF/ID register.
// Optional HOLD-cycle counter output stall_cycles under `define IFETCH_PERF_EN.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
`ifdef IFETCH_PERF_EN
    output logic [15:0] stall_cycles,
`endif
    output logic [5:0]  op
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD
    } fetchState_t;

    fetchState_t state;
    fetchState_t stateNext;

    logic [31:0] pc;
    logic [31:0] pcNext;
    logic [31:0] pcPlus4;
    logic [31:0] skidInstr;
    logic [31:0] skidPc4;
    logic [31:0] skidInstrNext;
    logic [31:0] skidPc4Next;
    logic        validNext;
    logic [31:0] instrNext;
    logic [31:0] pc4Next;
    logic        accept;

    assign pcPlus4   = pc + 32'd4;
    assign accept    = !stall || !if_id_valid;
    assign imem_req  = (state == REQ);
    assign imem_addr = pc;
    assign op        = if_id_instr[31:26];

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state and datapath loads; a taken branch overrides everything
    always_comb begin
        stateNext     = state;
        pcNext        = pc;
        validNext     = if_id_valid;
        instrNext     = if_id_instr;
        pc4Next       = if_id_pc4;
        skidInstrNext = skidInstr;
        skidPc4Next   = skidPc4;
        if (branch_taken) begin
            stateNext     = REQ;
            pcNext        = {branch_target[31:2], 2'b00};
            validNext     = 1'b0;
            instrNext     = 32'h0;
            skidInstrNext = 32'h0;
            skidPc4Next   = 32'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    stateNext = REQ;
                end
                REQ: begin
                    if (imem_ack) begin
                        pcNext = pcPlus4;
                        if (accept) begin
                            validNext = 1'b1;
                            instrNext = imem_rdata;
                            pc4Next   = pcPlus4;
                        end else begin
                            skidInstrNext = imem_rdata;
                            skidPc4Next   = pcPlus4;
                            stateNext     = HOLD;
                        end
                    end else if (accept) begin
                        validNext = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        validNext = 1'b1;
                        instrNext = skidInstr;
                        pc4Next   = skidPc4;
                        stateNext = REQ;
                    end
                end
                default: begin
                    stateNext = IDLE;
                end
            endcase
        end
    end

    // PC, skid buffer and IF/ID registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            skidInstr   <= 32'h0;
            skidPc4     <= 32'h0;
            if_id_valid <= 1'b0;
            if_id_instr <= 32'h0;
            if_id_pc4   <= 32'h0;
        end else begin
            pc          <= pcNext;
            skidInstr   <= skidInstrNext;
            skidPc4     <= skidPc4Next;
            if_id_valid <= validNext;
            if_id_instr <= instrNext;
            if_id_pc4   <= pc4Next;
        end
    end

`ifdef IFETCH_PERF_EN
    // Saturating count of cycles spent in HOLD; only reset clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= 16'h0;
        end else if (state == HOLD && stall_cycles != 16'hFFFF) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized scoreboard bench for instruction_fetch.
// Checks stall_cycles too when built with IFETCH_PERF_EN.
module tb_instruction_fetch;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic [5:0]  op;
`ifdef IFETCH_PERF_EN
    logic [15:0] stall_cycles;
    logic [15:0] wStallCycles;
`endif

    logic        wReq;
    logic [31:0] wAddr;
    logic        wAck;
    logic        wValid;
    logic [31:0] wInstr;
    logic [31:0] wPc4;
    logic [5:0]  wOp;

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
        .if_id_pc4(if_id_pc4),
`ifdef IFETCH_PERF_EN
        .stall_cycles(stall_cycles),
`endif
        .op(op)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dutW (
        .clk(clk), .rst(rst),
        .imem_req(wReq), .imem_addr(wAddr),
        .imem_ack(wAck), .imem_rdata(32'h1234_5678),
        .stall(1'b0), .branch_taken(1'b0),
        .branch_target(32'h0),
        .if_id_valid(wValid), .if_id_instr(wInstr),
        .if_id_pc4(wPc4),
`ifdef IFETCH_PERF_EN
        .stall_cycles(wStallCycles),
`endif
        .op(wOp)
    );

    int          nVec = 0;
    int          nErr = 0;
    int          memMode = 0;
    ent_t        q[$];
    logic [31:0] fetchPc;
    logic [31:0] reqPc;
    int          occNow;
    bit          branchNow;
    bit          prevBranch;
    bit          monEn = 0;
    int          perfModel;

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (memMode == 0) return 32'h0000_0020 + a;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic modelReset();
        q.delete();
        fetchPc    = 32'h0;
        perfModel  = 0;
        prevBranch = 0;
    endtask

    // Issue one cycle of stimulus and record what the fetch stream should do
    task automatic cycle(input bit st, input bit ack, input bit br,
                         input logic [31:0] tgt);
        stall         = st;
        imem_ack      = ack;
        branch_taken  = br;
        branch_target = tgt;
        imem_rdata    = memWord(imem_addr);
        occNow        = q.size();
        reqPc         = fetchPc;
        branchNow     = br;
        if (br) begin
            q.delete();
            fetchPc = {tgt[31:2], 2'b00};
        end else if (imem_req && ack) begin
            q.push_back('{instr: memWord(fetchPc), pc4: fetchPc + 32'd4});
            fetchPc = fetchPc + 32'd4;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: occupancy, address and consumed-entry checks
    always @(negedge clk) begin
        if (monEn) begin
            ent_t e;
            chk("valid", {31'b0, if_id_valid}, {31'b0, occNow > 0});
            chk("req", {31'b0, imem_req}, {31'b0, occNow < 2});
            chk("addr", imem_addr, reqPc);
            if (prevBranch) chk("flushNop", if_id_instr, 32'h0);
`ifdef IFETCH_PERF_EN
            chk("perf", {16'h0, stall_cycles}, perfModel[31:0]);
`endif
            if (if_id_valid && !stall && !branchNow && occNow > 0) begin
                e = q.pop_front();
                chk("instr", if_id_instr, e.instr);
                chk("pc4", if_id_pc4, e.pc4);
                chk("op", {26'b0, op}, {26'b0, e.instr[31:26]});
            end
            prevBranch = branchNow;
            if (occNow == 2 && perfModel != 65535) perfModel++;
        end
    end

    initial begin
        rst = 1; stall = 0; imem_ack = 0; branch_taken = 0;
        branch_target = 0; imem_rdata = 0; wAck = 0;
        modelReset();
        #12;
        chk("rstReq", {31'b0, imem_req}, 32'h0);
        chk("rstAddr", imem_addr, 32'h0);
        chk("rstValid", {31'b0, if_id_valid}, 32'h0);
        chk("rstInstr", if_id_instr, 32'h0);
        chk("rstPc4", if_id_pc4, 32'h0);
        chk("rstOp", {26'b0, op}, 32'h0);
        chk("rstWAddr", wAddr, 32'hFFFF_FFFC);
        rst = 0;
        @(posedge clk);
        #1;
        chk("firstReq", {31'b0, imem_req}, 32'h1);
        chk("firstAddr", imem_addr, 32'h0);
        chk("firstValid", {31'b0, if_id_valid}, 32'h0);
        chk("wReq", {31'b0, wReq}, 32'h1);
        monEn = 1;
        wAck = 1;
        for (int i = 1; i <= 2; i++) begin
            cycle(0, 1, 0, 0);
            if (i == 1) wAck = 0;
            chk("runAddr", imem_addr, 32'(4 * i));
            chk("runPc4", if_id_pc4, 32'(4 * i));
            chk("runValid", {31'b0, if_id_valid}, 32'h1);
            chk("runOp", {26'b0, op}, 32'h0);
        end
        chk("wrapPc4", wPc4, 32'h0);
        chk("wrapAddr", wAddr, 32'h0);
        chk("wrapInstr", wInstr, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 0, 0);
            chk("stallPc4", if_id_pc4, 32'h8);
            chk("holdReq", {31'b0, imem_req}, 32'h0);
        end
        cycle(0, 0, 0, 0);
        chk("unstallPc4", if_id_pc4, 32'hC);
        chk("unstallReq", {31'b0, imem_req}, 32'h1);
        cycle(0, 1, 1, 32'h0000_0103);
        chk("brValid", {31'b0, if_id_valid}, 32'h0);
        chk("brInstr", if_id_instr, 32'h0);
        chk("brAddr", imem_addr, 32'h0000_0100);
        cycle(0, 1, 0, 0);
        chk("brNewPc4", if_id_pc4, 32'h0000_0104);
        chk("brNewInstr", if_id_instr, memWord(32'h0000_0100));
        memMode = 1;
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 99) < 5, $urandom);
        end
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
        cycle(1, 1, 0, 0);
        chk("preRstHold", {31'b0, imem_req}, 32'h0);
        #2;
        monEn = 0;
        rst = 1;
        #1;
        chk("asyncValid", {31'b0, if_id_valid}, 32'h0);
        chk("asyncReq", {31'b0, imem_req}, 32'h0);
        chk("asyncPc", imem_addr, 32'h0);
        modelReset();
        stall = 0; imem_ack = 0; branch_taken = 0;
        @(posedge clk);
        #3;
        rst = 0;
        @(posedge clk);
        #1;
        chk("reReq", {31'b0, imem_req}, 32'h1);
        reqPc = 32'h0;
        occNow = 0;
        branchNow = 0;
        monEn = 1;
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 8,
                  $urandom_range(0, 99) < 3, $urandom);
        end
        monEn = 0;
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage and IF/ID pipeline register of the MIPS datapath, directly upstream of the opcode control unit. Holds the PC, issues word reads to instruction memory over a req/ack handshake, and registers the returned instruction together with PC+4 into IF/ID. The `op` field of the registered instruction is what the control unit decodes. Supports back-pressure from decode through a one-entry skid buffer, and flushes on a taken branch.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `imem_req`  out  1: fetch request; high only in state REQ.
- `imem_addr`  out  32: equals current `pc`.
- `imem_ack`  in  1: read data valid this cycle; ignored unless `imem_req` is high.
- `imem_rdata`  in  32: instruction word.
- `stall`  in  1: decode cannot accept a new IF/ID entry this cycle.
- `branch_taken`  in  1: redirect request.
- `branch_target`  in  32: redirect PC; bits [1:0] are forced to 0.
- `if_id_valid`  out  1: IF/ID register holds a real instruction.
- `if_id_instr`  out  32: registered instruction.
- `if_id_pc4`  out  32: PC of that instruction plus 4.
- `op`  out  6: `if_id_instr[31:26]`, feeding the control unit.

## Operation
- **Registers:**
  - `pc`, 32 bits.
  - `state`: IDLE, REQ or HOLD.
  - Skid buffer: `skid_instr` and `skid_pc4`.
  - IF/ID: `if_id_valid`, `if_id_instr`, `if_id_pc4`.
- **Accept condition:** `accept = !stall || !if_id_valid`. A stall never holds a bubble.
- **IDLE:**
  - Entered only from reset.
  - Moves to REQ on the next edge unconditionally.
- **REQ:**
  - `imem_req` is 1.
  - On `imem_ack` with `accept`:
    - IF/ID gets `imem_rdata` and `pc+4`, with valid set to 1.
    - `pc <= pc+4`; stay in REQ.
  - On `imem_ack` with `!accept`:
    - Skid buffer gets `imem_rdata` and `pc+4`.
    - `pc <= pc+4`; go to HOLD.
  - With no `imem_ack`:
    - If `accept`, clear `if_id_valid`, because decode consumed the entry.
    - Stay in REQ.
- **HOLD:**
  - `imem_req` is 0.
  - When `!stall`, IF/ID gets the skid contents with valid set to 1, and the state returns to REQ.
  - Otherwise everything holds.
- **Branch flush** (`branch_taken`=1, highest priority, any state except during reset):
  - `pc <= {branch_target[31:2],2'b00}`.
  - `if_id_valid <= 0` and `if_id_instr <= 0` (NOP).
  - Skid buffer is discarded.
  - State goes to REQ.
  - An `imem_ack` in the same cycle is dropped.
- **Arithmetic:** PC+4 is a 32-bit add modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- **Mid-operation reset:** aborts any outstanding request immediately. Skid contents are lost.

## Timing
- **Reset values:**
  - `pc=RESET_PC`, state IDLE.
  - `imem_req=0`, `imem_addr=RESET_PC`.
  - `if_id_valid=0`, `if_id_instr=0`, `if_id_pc4=0`, `op=0`.
  - Skid buffer zero.
- **First request:** `imem_req` rises one edge after `rst` deasserts.
- **Latency:** an `imem_ack` sampled at edge N is visible on `if_id_*` and `op` after edge N. The next address is presented after the same edge.
- **Throughput:** one instruction per cycle with a zero-wait memory and no stall.
- **Stall recovery:** the HOLD→REQ transition costs one cycle with `imem_req` low. The skid entry appears on IF/ID at that edge.
- **Combinational paths:**
  - `imem_req` and `imem_addr` come only from registers.
  - `op` is a pure slice of `if_id_instr`.
  - No path from input to output.

## Configuration
- **`IFETCH_PERF_EN` defined:**
  - Adds output `stall_cycles` (out, 16 bits).
  - It counts clock cycles spent in HOLD, saturates at 16'hFFFF, and is cleared by `rst` only.
  - Flush does not clear it.
- **`IFETCH_PERF_EN` undefined:**
  - Port and counter are absent.
  - All other behaviour is identical.

## Test plan
- **Reset then free-run:**
  - Stimulus: `RESET_PC=0`, ack always 1, `imem_rdata=32'h0000_0020+addr`.
  - Required: `imem_addr` sequence 0,4,8; `if_id_pc4` sequence 4,8,12; `op=0` each cycle; `if_id_valid` high from the second edge after reset release.
- **Stall with ack:**
  - Stimulus: `stall=1` for 3 cycles while IF/ID holds pc4=8 and ack returns addr 8.
  - Required: IF/ID holds pc4=8 for the 3 cycles, `imem_req` goes low in HOLD, and pc4=12 appears on the edge after `stall` falls.
- **Branch flush:**
  - Stimulus: `branch_taken=1`, `branch_target=32'h0000_0103`, simultaneous with an ack.
  - Required: `if_id_valid=0` and `if_id_instr=0` next cycle; `imem_addr=32'h0000_0100`; the acked data is never presented.
- **Wrap-around:**
  - Stimulus: `RESET_PC=32'hFFFF_FFFC`, then one ack.
  - Required: `if_id_pc4=0`, next `imem_addr=0`.
- **Async reset mid-HOLD:**
  - Stimulus: assert `rst` between edges while in HOLD.
  - Required: `if_id_valid` and `imem_req` drop immediately without a clock edge; `pc=RESET_PC`.
- **Perf counter** (with `IFETCH_PERF_EN`):
  - Stimulus: 5 HOLD cycles.
  - Required: `stall_cycles=5`.
